// File: rtl/spart_driver.sv
// spart_driver: bus master that programs the SPART baud divisor from br_cfg
// and echoes every received byte back through a small FIFO.
// Ports: clk, rst (async, active-low); br_cfg, rda, tbr in;
// iocs, iorw, ioaddr out; databus inout; cfg_done, ovf, level out.
module spart_driver #(
  parameter int          DEPTH = 4,
  parameter logic [15:0] DIV0  = 16'd10416,
  parameter logic [15:0] DIV1  = 16'd5208,
  parameter logic [15:0] DIV2  = 16'd2604,
  parameter logic [15:0] DIV3  = 16'd1302
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               br_cfg,
  input  logic                     rda,
  input  logic                     tbr,
  output logic                     iocs,
  output logic                     iorw,
  output logic [1:0]               ioaddr,
  inout  wire  [7:0]               databus,
  output logic                     cfg_done,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LONE = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  typedef enum logic [1:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    TX_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [1:0] br_s1, br_s2;
  logic [1:0] cfg_sel, cfg_cur;
  logic       run;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic [15:0] div;
  logic [7:0]  dout;
  logic        drive;
  logic        push, pop, drop;
  logic        sel_load, cfg_fin, reconf;
  logic        full, empty;

  assign full  = (level == FULL);
  assign empty = (level == '0);

  // Synchronizer is deliberately not reset so it already holds the
  // switch setting when reset releases and the first divisor is right.
  always_ff @(posedge clk) begin
    br_s1 <= br_cfg;
    br_s2 <= br_s1;
  end

  always_comb begin
    case (cfg_sel)
      2'b00:   div = DIV0;
      2'b01:   div = DIV1;
      2'b10:   div = DIV2;
      default: div = DIV3;
    endcase
  end

  // run holds the bus idle for the reset cycle while state sits in CFG_LO.
  always_comb begin
    state_nxt = state;
    iocs      = 1'b0;
    iorw      = 1'b1;
    ioaddr    = 2'b00;
    drive     = 1'b0;
    dout      = 8'h00;
    push      = 1'b0;
    pop       = 1'b0;
    drop      = 1'b0;
    sel_load  = 1'b0;
    cfg_fin   = 1'b0;
    reconf    = 1'b0;
    if (!run) begin
      sel_load = 1'b1;
      drop     = rda;
    end else begin
      unique case (state)
        CFG_LO: begin
          iocs      = 1'b1;
          iorw      = 1'b0;
          ioaddr    = 2'b10;
          drive     = 1'b1;
          dout      = div[7:0];
          drop      = rda;
          state_nxt = CFG_HI;
        end
        CFG_HI: begin
          iocs      = 1'b1;
          iorw      = 1'b0;
          ioaddr    = 2'b11;
          drive     = 1'b1;
          dout      = div[15:8];
          drop      = rda;
          cfg_fin   = 1'b1;
          state_nxt = IDLE;
        end
        IDLE: begin
          if (rda) begin
            push = !full;
            drop = full;
          end else if (br_s2 != cfg_cur && tbr) begin
            reconf    = 1'b1;
            sel_load  = 1'b1;
            state_nxt = CFG_LO;
          end else if (!empty && tbr) begin
            iocs      = 1'b1;
            iorw      = 1'b0;
            drive     = 1'b1;
            dout      = mem[rd_ptr];
            pop       = 1'b1;
            state_nxt = TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (rda) begin
            push = !full;
            drop = full;
          end
          if (!tbr) state_nxt = IDLE;
        end
        default: state_nxt = CFG_LO;
      endcase
    end
  end

  assign databus = drive ? dout : 8'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CFG_LO;
      run      <= 1'b0;
      cfg_sel  <= 2'b00;
      cfg_cur  <= 2'b00;
      cfg_done <= 1'b0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nxt;
      if (sel_load) cfg_sel <= br_s2;
      if (cfg_fin) begin
        cfg_cur  <= br_s2;
        cfg_done <= 1'b1;
      end
      if (reconf) cfg_done <= 1'b0;
      if (drop)   ovf      <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PONE;
        level  <= level + LONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PONE;
        level  <= level - LONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= databus;
  end

endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: directed bench for spart_driver with a tiny SPART
// model driving RX data on databus whenever rda is high.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       cfg_done;
  logic       ovf;
  logic [2:0] level;
  logic [7:0] spart_d;
  logic       probe;
  wire  [7:0] databus;

  int n_chk  = 0;
  int n_fail = 0;

  assign databus = (rda || probe) ? spart_d : 8'bz;

  always #5 clk = ~clk;

  spart_driver dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .rda      (rda),
    .tbr      (tbr),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .cfg_done (cfg_done),
    .ovf      (ovf),
    .level    (level)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A released bus lets the probe value through untouched.
  task automatic bus_free(input string tag);
    spart_d = 8'hC3;
    probe   = 1'b1;
    #1;
    chk(tag, 32'(databus), 32'h0000_00C3);
    probe = 1'b0;
    #1;
  endtask

  task automatic wait_write(input string tag,
                            input logic [1:0] a,
                            input logic [7:0] d);
    int n;
    n = 0;
    while (iocs !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(iocs), 32'd1);
    chk({tag, "_rw"}, 32'(iorw), 32'd0);
    chk({tag, "_addr"}, 32'(ioaddr), 32'(a));
    chk({tag, "_data"}, 32'(databus), 32'(d));
  endtask

  task automatic rx(input logic [7:0] d);
    spart_d = d;
    rda     = 1'b1;
    tick();
    rda = 1'b0;
    #1;
  endtask

  task automatic drain(input string tag, input logic [7:0] d);
    tbr = 1'b1;
    #1;
    wait_write(tag, 2'b00, d);
    tick();
    tbr = 1'b0;
    tick();
  endtask

  initial begin
    int maxl;
    int cnt;
    rst     = 1'b0;
    br_cfg  = 2'b01;
    rda     = 1'b0;
    tbr     = 1'b0;
    spart_d = 8'h00;
    probe   = 1'b0;

    repeat (3) tick();
    chk("rst_iocs", 32'(iocs), 32'd0);
    chk("rst_iorw", 32'(iorw), 32'd1);
    chk("rst_addr", 32'(ioaddr), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    bus_free("rst_bus");

    rst = 1'b1;
    tick();
    chk("cfg1_iocs", 32'(iocs), 32'd1);
    chk("cfg1_rw", 32'(iorw), 32'd0);
    chk("cfg1_addr", 32'(ioaddr), 32'h2);
    chk("cfg1_data", 32'(databus), 32'h58);
    tick();
    chk("cfg2_addr", 32'(ioaddr), 32'h3);
    chk("cfg2_data", 32'(databus), 32'h14);
    chk("cfg2_done", 32'(cfg_done), 32'd0);
    tick();
    chk("cfg3_done", 32'(cfg_done), 32'd1);
    chk("cfg3_iocs", 32'(iocs), 32'd0);
    bus_free("cfg3_bus");

    tbr = 1'b1;
    rx(8'hA5);
    chk("echo_level1", 32'(level), 32'd1);
    wait_write("echo", 2'b00, 8'hA5);
    tick();
    chk("echo_level0", 32'(level), 32'd0);
    tbr = 1'b0;
    tick();

    maxl = 0;
    for (int i = 0; i < 10; i++) begin
      tbr = 1'b1;
      rx(8'h30 + 8'(i));
      if (int'(level) > maxl) maxl = int'(level);
      wait_write($sformatf("wrap%0d", i), 2'b00, 8'h30 + 8'(i));
      tick();
      if (int'(level) > maxl) maxl = int'(level);
      tbr = 1'b0;
      tick();
    end
    chk("wrap_maxlvl", 32'(maxl), 32'd1);
    chk("wrap_ovf", 32'(ovf), 32'd0);

    tbr    = 1'b1;
    br_cfg = 2'b11;
    cnt    = 0;
    while (cfg_done === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("rcfg_fall", 32'(cfg_done), 32'd0);
    chk("rcfg_lo_addr", 32'(ioaddr), 32'h2);
    chk("rcfg_lo_data", 32'(databus), 32'h16);
    tick();
    chk("rcfg_hi_addr", 32'(ioaddr), 32'h3);
    chk("rcfg_hi_data", 32'(databus), 32'h05);
    tick();
    chk("rcfg_rise", 32'(cfg_done), 32'd1);

    tbr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rx(8'(i));
      tick();
    end
    chk("burst_level", 32'(level), 32'd4);
    chk("burst_ovf", 32'(ovf), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      drain($sformatf("burst%0d", k), 8'(k));
    end
    tbr = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (iocs === 1'b1) cnt++;
      tick();
    end
    chk("burst_no05", 32'(cnt), 32'd0);
    chk("burst_empty", 32'(level), 32'd0);

    tbr = 1'b0;
    rx(8'hAA);
    rx(8'hBB);
    rx(8'hCC);
    tbr = 1'b1;
    #1;
    wait_write("rtx", 2'b00, 8'hAA);
    tick();
    chk("rtx_level", 32'(level), 32'd2);
    chk("rtx_ovf", 32'(ovf), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rtx_iocs", 32'(iocs), 32'd0);
    chk("rtx_lvl0", 32'(level), 32'd0);
    chk("rtx_ovf0", 32'(ovf), 32'd0);
    chk("rtx_done0", 32'(cfg_done), 32'd0);
    bus_free("rtx_bus");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst2_lo_addr", 32'(ioaddr), 32'h2);
    chk("rst2_lo_data", 32'(databus), 32'h16);
    tick();
    chk("rst2_hi_data", 32'(databus), 32'h05);
    tick();
    chk("rst2_done", 32'(cfg_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
# spart_driver

Bus-master state machine on the processor side of the SPART serial port. After reset it programs the baud divisor from the `br_cfg` switches. It then captures every received byte into a small FIFO and echoes each one back through the SPART transmitter. It owns `iocs`/`iorw`/`ioaddr` and shares the bidirectional `databus` with the SPART.

## Interface
- `DEPTH`, 4: echo FIFO depth; power of two, ≥2.
- `DIV0`, 16'd10416: divisor for `br_cfg`=00 (4800 baud at 50 MHz).
- `DIV1`, 16'd5208: divisor for `br_cfg`=01 (9600 baud).
- `DIV2`, 16'd2604: divisor for `br_cfg`=10 (19200 baud).
- `DIV3`, 16'd1302: divisor for `br_cfg`=11 (38400 baud).

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `br_cfg` in 2: baud select; quasi-static, synchronized internally with 2 flops.
- `rda` in 1: SPART receive-data-available; one-cycle pulse.
- `tbr` in 1: SPART transmit-buffer-ready; high = transmitter idle.
- `iocs` out 1: chip select, write strobe.
- `iorw` out 1: 1 = read, 0 = write.
- `ioaddr` out 2: 00 = TX/RX data, 10 = divisor low byte, 11 = divisor high byte.
- `databus` inout 8: driven only during write cycles, otherwise `8'bz`.
- `cfg_done` out 1: high once the divisor for the current `br_cfg` has been written.
- `ovf` out 1: sticky; a received byte was dropped.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Bus idle state (every cycle not listed below): `iocs`=0, `iorw`=1, `ioaddr`=00, `databus` released. In this state the SPART drives RX data whenever `rda`=1.
- FSM states: CFG_LO, CFG_HI, IDLE, TX_WAIT.
- CFG_LO: `iocs`=1, `iorw`=0, `ioaddr`=10, drive `DIVn[7:0]`. Next state is CFG_HI.
- CFG_HI: `iocs`=1, `iorw`=0, `ioaddr`=11, drive `DIVn[15:8]`. Latch the synchronized `br_cfg` as `cfg_cur`, set `cfg_done`=1, go to IDLE.
- `DIVn` is selected by the synchronized `br_cfg` sampled on entry to CFG_LO. It is held constant through CFG_HI.
- IDLE, with priority order:
  1. `rda`=1: capture `databus` into the FIFO this cycle. If full, drop the byte and set `ovf`.
  2. Else, if synchronized `br_cfg` ≠ `cfg_cur` and `tbr`=1: clear `cfg_done` and go to CFG_LO.
  3. Else, if FIFO non-empty and `tbr`=1: write cycle (`iocs`=1, `iorw`=0, `ioaddr`=00, drive FIFO head), pop, go to TX_WAIT.
- TX_WAIT: bus idle. Wait for `tbr`=0, then return to IDLE, which needs a fresh `tbr`=1 before the next write. `rda` captures still occur in TX_WAIT.
- `rda` during CFG_LO or CFG_HI: the byte is lost, `ovf` is set, and the FIFO is unchanged.
- Push and pop never occur in the same cycle, because writes are issued only when `rda`=0.
- FIFO: circular buffer with wrapping pointers.
  - `level` ranges 0..DEPTH.
  - Full means `level`=DEPTH; the pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `iocs`=0, `iorw`=1, `ioaddr`=00, `databus`=z.
  - `cfg_done`=0, `ovf`=0, `level`=0, FIFO empty, FSM in CFG_LO.
  - `cfg_cur` = 00, but always rewritten.
- Config:
  - First clock after reset release: CFG_LO on the bus.
  - Second clock: CFG_HI on the bus.
  - `cfg_done`=1 from the third cycle.
- Capture: zero latency, with `databus` sampled on the clock edge where `rda`=1. `level` increments the next cycle.
- Echo: with `tbr`=1, the write cycle occurs on the cycle after the capture. `level` decrements the cycle after the write.
- `br_cfg` change to reconfiguration start: 2 sync cycles plus waiting for `tbr`=1.
- Reset assertion mid-operation: all state returns to its reset value immediately, and `databus` is released asynchronously.

## Test plan
- Reset release with `br_cfg`=01:
  - Cycle 1: `ioaddr`=10, `databus`=8'h58.
  - Cycle 2: `ioaddr`=11, `databus`=8'h14.
  - Cycle 3: `cfg_done`=1.
- Single echo: `rda` pulse with SPART data 8'hA5 and `tbr`=1.
  - Next cycle: `iocs`=1, `iorw`=0, `ioaddr`=00, `databus`=8'hA5.
  - `level` goes 1 then 0.
- Burst with `tbr` held 0: 5 `rda` pulses carrying 8'h01..8'h05 with DEPTH=4.
  - Result: `level`=4, `ovf`=1.
  - After `tbr` toggles, writes 01, 02, 03, 04 appear in order; 05 is never written.
- Wrap-around: 10 bytes echoed one at a time.
  - Output order equals input order.
  - `level` never exceeds 1, and `ovf` stays 0.
- Reconfiguration: `br_cfg` changes 01→11 while idle with `tbr`=1.
  - `cfg_done` falls.
  - Writes 8'h16 to address 10, then 8'h05 to address 11.
  - `cfg_done` rises again.
- Reset asserted during TX_WAIT with `level`=2:
  - Immediately: `iocs`=0, `databus`=z, `level`=0, `ovf`=0.
  - After release, the config sequence restarts.
